// File: rtl/bip_pkg.sv
// Shared BIP program-memory constants: default widths, HLT opcode, opcode field position and
// FSM state encodings.
package bip_pkg;
  localparam int BIP_ADDR_W = 11;
  localparam int BIP_DATA_W = 16;

  localparam logic [4:0] OP_HLT = 5'b00000;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;

  typedef logic [1:0] state_t;
  localparam state_t ST_EMPTY   = 2'd0;
  localparam state_t ST_LOAD_LO = 2'd1;
  localparam state_t ST_LOAD_HI = 2'd2;
  localparam state_t ST_RUN     = 2'd3;
endpackage

// File: rtl/bip_prog_ram.sv
// Simple dual-port instruction store: one synchronous write port, one registered read port.
// The array and the read register carry no reset so the store maps onto block RAM.
module bip_prog_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bip_program_memory.sv
// BIP program memory: byte-serial loader, CPU hold until a full program is present, and fetch
// in RUN (instr_out two edges after rd_en is first sampled). Optional PROG_CHECKSUM_EN adds prog_checksum.
module bip_program_memory
  import bip_pkg::*;
#(
  parameter int ADDR_W = BIP_ADDR_W,
  parameter int DATA_W = BIP_DATA_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address_input,
  input  logic              rd_en,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  input  logic              load_start,
  input  logic [7:0]        load_byte,
  input  logic              load_byte_valid,
  output logic              load_done,
  output logic              cpu_run,
  output logic [ADDR_W:0]   load_count
`ifdef PROG_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] prog_checksum
`endif
);

  state_t            r_state;
  state_t            w_next_state;
  logic [7:0]        r_lo_byte;
  logic [ADDR_W:0]   r_load_count;
  logic              r_load_done;
  logic              r_rd_pend;
  logic              r_rd_oob;
  logic [DATA_W-1:0] r_instr_out;
  logic              r_instr_valid;
  logic [DATA_W-1:0] w_ram_rdata;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_wr_en;
  logic              w_finish;
  logic              w_rd_fire;
  logic              w_cpu_run;

  assign w_wr_data = {load_byte, r_lo_byte};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (load_start) begin
      w_next_state = ST_LOAD_LO;
    end else begin
      case (r_state)
        ST_LOAD_LO: if (load_byte_valid) w_next_state = ST_LOAD_HI;
        ST_LOAD_HI: if (load_byte_valid) w_next_state = w_finish ? ST_RUN : ST_LOAD_LO;
        default:    w_next_state = r_state;
      endcase
    end
  end

  // The program ends on an HLT word or when the last RAM slot has been written.
  always_comb begin
    w_wr_en   = (r_state == ST_LOAD_HI) && load_byte_valid && !load_start;
    w_finish  = w_wr_en && ((w_wr_data[OPC_MSB:OPC_LSB] == OP_HLT) ||
                            (r_load_count == (ADDR_W+1)'(DEPTH-1)));
    w_rd_fire = rd_en && (r_state == ST_RUN);
    w_cpu_run = (r_state == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo_byte    <= '0;
      r_load_count <= '0;
      r_load_done  <= 1'b0;
    end else begin
      r_load_done <= w_finish;
      if (load_start)        r_load_count <= '0;
      else if (w_wr_en)      r_load_count <= r_load_count + 1'b1;
      if ((r_state == ST_LOAD_LO) && load_byte_valid && !load_start)
        r_lo_byte <= load_byte;
    end
  end

  bip_prog_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_load_count[ADDR_W-1:0]),
    .i_wdata (w_wr_data),
    .i_re    (w_rd_fire),
    .i_raddr (address_input),
    .o_rdata (w_ram_rdata)
  );

  // Addresses past the loaded program read as HLT so stale RAM contents never execute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend     <= 1'b0;
      r_rd_oob      <= 1'b0;
      r_instr_out   <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_rd_pend     <= w_rd_fire;
      r_rd_oob      <= ({1'b0, address_input} >= r_load_count);
      r_instr_valid <= r_rd_pend;
      if (r_rd_pend) r_instr_out <= r_rd_oob ? '0 : w_ram_rdata;
    end
  end

`ifdef PROG_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_checksum <= '0;
    else if (load_start) r_checksum <= '0;
    else if (w_wr_en)    r_checksum <= r_checksum ^ w_wr_data;
  end

  assign prog_checksum = r_checksum;
`endif

  assign instr_out   = r_instr_out;
  assign instr_valid = r_instr_valid;
  assign load_done   = r_load_done;
  assign cpu_run     = w_cpu_run;
  assign load_count  = r_load_count;

endmodule

// File: tb/tb_bip_program_memory.sv
// Directed bench for bip_program_memory: loader FSM, HLT/full termination, fetch gating and
// out-of-range reads, async reset mid-load, and the optional PROG_CHECKSUM_EN output.
module tb_bip_program_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] address_input = '0;
  logic        rd_en = 1'b0;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        load_start = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_byte_valid = 1'b0;
  logic        load_done;
  logic        cpu_run;
  logic [11:0] load_count;
`ifdef PROG_CHECKSUM_EN
  logic [15:0] prog_checksum;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] w, xref, w_first, w_last;

  always #5 clk = ~clk;

  bip_program_memory dut (
`ifdef PROG_CHECKSUM_EN
    .prog_checksum   (prog_checksum),
`endif
    .clk             (clk),
    .rst_n           (rst_n),
    .address_input   (address_input),
    .rd_en           (rd_en),
    .instr_out       (instr_out),
    .instr_valid     (instr_valid),
    .load_start      (load_start),
    .load_byte       (load_byte),
    .load_byte_valid (load_byte_valid),
    .load_done       (load_done),
    .cpu_run         (cpu_run),
    .load_count      (load_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_byte = b;
    load_byte_valid = 1'b1;
    step();
    load_byte_valid = 1'b0;
  endtask

  task automatic restart();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  initial begin
    // Reset state and fetch ignored while EMPTY
    step(); step();
    check("rst_instr_out", instr_out, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_load_done", load_done, 0);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_load_count", load_count, 0);
    rst_n = 1'b1;
    rd_en = 1'b1; address_input = 11'd0;
    step(); step();
    check("empty_rd_valid", instr_valid, 0);
    check("empty_rd_out", instr_out, 0);
    rd_en = 1'b0;
    send_byte(8'hAA);
    check("empty_byte_ignored", load_count, 0);

    // 0x1234, 0x0800 (opcode 1, keeps loading), then 0x0000 (HLT) ends the program
    restart();
    check("ld_start_count", load_count, 0);
    send_byte(8'h34); send_byte(8'h12);
    check("ld_count_1", load_count, 1);
    send_byte(8'h00); send_byte(8'h08);
    check("ld_count_2", load_count, 2);
    check("ld_no_done_op1", load_done, 0);
    check("ld_no_run_op1", cpu_run, 0);
    send_byte(8'h00); send_byte(8'h00);
    check("hlt_done", load_done, 1);
    check("hlt_run", cpu_run, 1);
    check("hlt_count", load_count, 3);
    step();
    check("done_one_cycle", load_done, 0);

    // Back-to-back fetches, including one past load_count
    rd_en = 1'b1; address_input = 11'd0;
    step();
    address_input = 11'd1;
    step();
    check("rd0_out", instr_out, 16'h1234);
    check("rd0_valid", instr_valid, 1);
    address_input = 11'd5;
    step();
    check("rd1_out", instr_out, 16'h0800);
    rd_en = 1'b0;
    step();
    check("rd5_oob_out", instr_out, 16'h0000);
    check("rd5_valid", instr_valid, 1);
    step();
    check("idle_valid", instr_valid, 0);
    send_byte(8'h55);
    check("run_byte_ignored_cnt", load_count, 3);
    check("run_byte_ignored_run", cpu_run, 1);

    // load_start beats a simultaneous byte; the would-be HLT high byte is dropped
    restart();
    check("reload_run_low", cpu_run, 0);
    check("reload_count0", load_count, 0);
    send_byte(8'h11);
    load_start = 1'b1; load_byte = 8'h00; load_byte_valid = 1'b1;
    step();
    load_start = 1'b0; load_byte_valid = 1'b0;
    check("drop_count", load_count, 0);
    check("drop_done", load_done, 0);
    check("drop_run", cpu_run, 0);
    send_byte(8'hFF); send_byte(8'h07);
    check("hlt_operand_done", load_done, 1);
    check("hlt_operand_count", load_count, 1);
    rd_en = 1'b1; address_input = 11'd0;
    step();
    address_input = 11'd1;
    step();
    check("reload_rd0", instr_out, 16'h07FF);
    rd_en = 1'b0;
    step();
    check("stale_addr1_masked", instr_out, 16'h0000);

    // Async reset while in LOAD_HI
    restart();
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h56);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", load_count, 0);
    check("arst_run", cpu_run, 0);
    step();
    rst_n = 1'b1;
    rd_en = 1'b1; address_input = 11'd0;
    step(); step();
    check("arst_rd_ignored", instr_valid, 0);
    rd_en = 1'b0;
    restart();
    send_byte(8'h42); send_byte(8'h00);
    check("arst_reload_run", cpu_run, 1);
    rd_en = 1'b1; address_input = 11'd0;
    step();
    rd_en = 1'b0;
    step();
    check("arst_reload_rd", instr_out, 16'h0042);

    // Fill all 2048 words with non-HLT opcodes; RUN entered on the last write
    restart();
    xref = '0;
    for (int i = 0; i < 2048; i++) begin
      w = {5'((i % 31) + 1), 11'(i)};
      xref ^= w;
      if (i == 0) w_first = w;
      if (i == 2047) w_last = w;
      send_byte(w[7:0]);
      send_byte(w[15:8]);
      if (i == 2046) check("full_minus1_no_run", cpu_run, 0);
    end
    check("full_done", load_done, 1);
    check("full_run", cpu_run, 1);
    check("full_count", load_count, 12'd2048);
`ifdef PROG_CHECKSUM_EN
    check("full_checksum", prog_checksum, xref);
`endif
    rd_en = 1'b1; address_input = 11'd0;
    step();
    address_input = 11'd2047;
    step();
    check("full_rd0", instr_out, w_first);
    rd_en = 1'b0;
    step();
    check("full_rd2047", instr_out, w_last);
`ifdef PROG_CHECKSUM_EN
    check("checksum_stable_run", prog_checksum, xref);
    restart();
    check("checksum_cleared", prog_checksum, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
